// File: rtl/msg_serialiser_if.sv
// FIFO-side and UART-side signals of msg_serialiser, bundled as one interface.
// master = the serialiser itself; slave = the FIFO/UART environment around it.
interface msg_serialiser_if #(
   parameter int unsigned WORD_SIZE        = 8,
   parameter int unsigned WORDS_PER_PACKET = 4,
   parameter int unsigned LEN_WIDTH        = $clog2(WORDS_PER_PACKET + 1)
);
   logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_in;
   logic [LEN_WIDTH-1:0]                  data_in_len;
   logic                                  data_in_ready;
   logic                                  data_in_req;
   logic                                  uart_ready;
   logic [WORD_SIZE-1:0]                  data_out;
   logic                                  data_out_req;
   logic                                  busy;

   modport master (
      input  data_in, data_in_len, data_in_ready, uart_ready,
      output data_in_req, data_out, data_out_req, busy
   );

   modport slave (
      output data_in, data_in_len, data_in_ready, uart_ready,
      input  data_in_req, data_out, data_out_req, busy
   );
endinterface

// File: rtl/msg_serialiser.sv
// Fetches one wide message from a FIFO and streams it word by word to a UART.
// Optional trailing XOR checksum word: define MSG_SERIALISER_CHECKSUM_EN.
module msg_serialiser #(
   parameter int unsigned WORD_SIZE        = 8,
   parameter int unsigned WORDS_PER_PACKET = 4,
   parameter int unsigned LEN_WIDTH        = $clog2(WORDS_PER_PACKET + 1),
   parameter bit          MSB_FIRST        = 1'b0
) (
   input  logic             clk,
   input  logic             n_reset,
   msg_serialiser_if.master bus
);

   localparam int unsigned CTR_W = LEN_WIDTH + 1;
   localparam int unsigned MSG_W = WORD_SIZE * WORDS_PER_PACKET;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_WAIT,
      S_SEND,
      S_GAP
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [MSG_W-1:0]     r_msg;
   logic [LEN_WIDTH-1:0] r_len;
   logic [CTR_W-1:0]     r_ctr;
   logic [WORD_SIZE-1:0] r_data_out;
   logic                 r_data_in_req;
   logic                 r_data_out_req;
   logic                 r_busy;

   logic [LEN_WIDTH-1:0] w_len_clamp;
   logic [CTR_W-1:0]     w_len_ext;
   logic [CTR_W-1:0]     w_idx;
   logic [WORD_SIZE-1:0] w_word;
   logic [WORD_SIZE-1:0] w_tx_word;
   logic                 w_last;

   assign w_len_ext = CTR_W'(r_len);

   // Oversized lengths from the FIFO are clamped to the payload capacity.
   always_comb begin
      w_len_clamp = bus.data_in_len;
      if (bus.data_in_len > LEN_WIDTH'(WORDS_PER_PACKET)) begin
         w_len_clamp = LEN_WIDTH'(WORDS_PER_PACKET);
      end
   end

   // Word index for the current counter value in the configured order.
   always_comb begin
      if (MSB_FIRST) begin
         w_idx = w_len_ext - CTR_W'(1) - r_ctr;
      end else begin
         w_idx = r_ctr;
      end
   end

   always_comb begin
      w_word = '0;
      for (int unsigned i = 0; i < WORDS_PER_PACKET; i++) begin
         if (w_idx == CTR_W'(i)) begin
            w_word = r_msg[i*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

`ifdef MSG_SERIALISER_CHECKSUM_EN
   logic [WORD_SIZE-1:0] r_chk;

   // Counter reaching len means the payload is done and the checksum is next.
   assign w_last    = (r_ctr == w_len_ext);
   assign w_tx_word = (r_ctr == w_len_ext) ? r_chk : w_word;
`else
   assign w_last    = ((r_ctr + CTR_W'(1)) == w_len_ext);
   assign w_tx_word = w_word;
`endif

   // State register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.data_in_ready) w_next = S_FETCH;
         S_FETCH: w_next = S_LOAD;
         S_LOAD:  w_next = (w_len_clamp == '0) ? S_IDLE : S_WAIT;
         S_WAIT:  if (bus.uart_ready) w_next = S_SEND;
         S_SEND:  w_next = w_last ? S_IDLE : S_GAP;
         S_GAP:   w_next = S_WAIT;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: message capture, word counter, output word and checksum.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_msg      <= '0;
         r_len      <= '0;
         r_ctr      <= '0;
         r_data_out <= '0;
`ifdef MSG_SERIALISER_CHECKSUM_EN
         r_chk      <= '0;
`endif
      end else begin
         case (r_state)
            S_LOAD: begin
               r_msg <= bus.data_in;
               r_len <= w_len_clamp;
               r_ctr <= '0;
`ifdef MSG_SERIALISER_CHECKSUM_EN
               r_chk <= '0;
`endif
            end
            S_WAIT: begin
               if (bus.uart_ready) begin
                  r_data_out <= w_tx_word;
               end
            end
            S_SEND: begin
               r_ctr <= r_ctr + CTR_W'(1);
`ifdef MSG_SERIALISER_CHECKSUM_EN
               if (r_ctr < w_len_ext) begin
                  r_chk <= r_chk ^ r_data_out;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   // Strobes and busy are registered decodes of the state being entered.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_data_in_req  <= 1'b0;
         r_data_out_req <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_data_in_req  <= (w_next == S_FETCH);
         r_data_out_req <= (w_next == S_SEND);
         r_busy         <= (w_next != S_IDLE);
      end
   end

   assign bus.data_in_req  = r_data_in_req;
   assign bus.data_out_req = r_data_out_req;
   assign bus.data_out     = r_data_out;
   assign bus.busy         = r_busy;

endmodule
